uart_tx: RTL and testbench



---
 rtl/uart_tx.sv | 146 ++++++++++++++
 tb/tb_uart_tx.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx -- UART 8N1 transmitter.
//
// Serialises one byte per frame onto the serial line:
// a start bit (0), eight data bits LSB first, and a stop bit (1).
// Each bit lasts CLKS_PER_BIT clocks. There is no FIFO. A request made
// while a frame is in flight is dropped.
//
// Ports:
//   clk       system clock, all logic on the rising edge
//   reset     synchronous reset, active-high (wins over tx_start)
//   tx_start  send request, sampled every cycle, honoured only in IDLE
//   tx_data   byte to send, captured on the accept cycle only
//   tx        serial line, idle high (registered)
//   tx_busy   high while a frame is on the line (registered)
//   tx_done   one-cycle pulse in the first IDLE cycle after the stop bit
// ---------------------------------------------------------------------------
module uart_tx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_d, busy_d, done_d;
    logic             bit_end;

    // Last clock of the current bit period.
    assign bit_end = (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx      <= tx_d;
            tx_busy <= busy_d;
            tx_done <= done_d;
        end
    end

    // The outputs are registered. Every *_d value below is the line
    // state for the next cycle. So tx can only move at a bit boundary,
    // and the line cannot glitch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx;
        busy_d  = tx_busy;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d  = '0;
                tx_d   = 1'b1;
                busy_d = 1'b0;
                // This is also the done cycle, so back-to-back frames
                // are accepted here.
                if (tx_start) begin
                    shift_d = tx_data;
                    state_d = START;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end

            START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        // shift_q[1] becomes bit 0 once the shift lands.
                        tx_d  = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            STOP: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx -- scoreboard bench for uart_tx.
//
// Two instances share one stimulus stream: CLKS_PER_BIT = 4 and = 2.
// For each instance:
//   - a reference model decides from the accept rule which bytes are
//     accepted, and when. It pushes {byte, expected first START cycle}.
//   - a line monitor pops an entry when it sees a start bit. It then
//     checks every cycle of the frame: the line level from the 8N1
//     frame layout, tx_busy, and tx_done. It also decodes the byte by
//     sampling at bit centres.
// ---------------------------------------------------------------------------
module tb_uart_tx;

    typedef struct {
        logic [7:0] data;
        int         start;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_start;
    logic [7:0] tx_data;
    int         cyc = 0;
    bit         mon_en = 1'b0;
    bit         stim_done = 1'b0;
    int         n_cmp = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_fail++;
            if (n_fail <= 60)
                $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int C = (g == 0) ? 4 : 2;

        logic tx_w, busy_w, done_w;
        exp_t sb[$];

        uart_tx #(
            .CLKS_PER_BIT(C),
            .CNT_W       (16)
        ) dut (
            .clk     (clk),
            .reset   (reset),
            .tx_start(tx_start),
            .tx_data (tx_data),
            .tx      (tx_w),
            .tx_busy (busy_w),
            .tx_done (done_w)
        );

        // Reference model. The line is free again at edge free_at.
        // A frame accepted at edge e occupies 10*C cycles, and the
        // done cycle follows, so the next accept is possible at
        // edge e + 10*C + 1.
        int free_at = 0;
        initial begin : model
            forever begin
                @(posedge clk);
                if (reset === 1'b1) begin
                    free_at = cyc + 1;
                end else if (tx_start === 1'b1 && cyc >= free_at) begin
                    sb.push_back('{tx_data, cyc + 1});
                    free_at = cyc + 10 * C + 1;
                end
            end
        end

        // Line monitor.
        int         phase = -1;
        int         k;
        exp_t       cur;
        logic [7:0] dec;
        logic       stop_bit;
        logic       exp_bit;
        logic [2:0] bi;
        bit         final_chk = 1'b0;

        function automatic string nm(input string s);
            return $sformatf("C%0d_%s", C, s);
        endfunction

        initial begin : monitor
            forever begin
                @(negedge clk);
                if (mon_en) begin
                    if (phase < 0) begin
                        if (tx_w === 1'b0) begin
                            phase = 0;
                            if (sb.size() == 0) begin
                                check(nm("unexpected_frame"), 32'd1, 32'd0);
                                cur = '{8'h00, cyc};
                            end else begin
                                cur = sb.pop_front();
                            end
                            check(nm("frame_start_cycle"), 32'(cyc), 32'(cur.start));
                            dec      = 8'h00;
                            stop_bit = 1'b0;
                        end
                    end else begin
                        phase++;
                    end

                    if (phase < 0) begin
                        check(nm("idle_lines"), 32'({tx_w, busy_w, done_w}), 32'b100);
                    end else if (phase < 10 * C) begin
                        k = phase / C;
                        bi = 3'(k - 1);
                        if (k == 0) exp_bit = 1'b0;
                        else if (k == 9) exp_bit = 1'b1;
                        else exp_bit = cur.data[bi];
                        check(nm("frame_lines"), 32'({tx_w, busy_w, done_w}), 32'({exp_bit, 2'b10}));
                        if (phase % C == C / 2) begin
                            if (k >= 1 && k <= 8) dec[bi] = tx_w;
                            if (k == 9) stop_bit = tx_w;
                        end
                    end else begin
                        check(nm("done_lines"), 32'({tx_w, busy_w, done_w}), 32'b101);
                        check(nm("decoded_byte"), 32'(dec), 32'(cur.data));
                        check(nm("stop_bit"), 32'(stop_bit), 32'd1);
                        phase = -1;
                    end

                    // A reset here takes effect at the next edge. It
                    // abandons the frame, and the next cycle must be idle.
                    if (reset === 1'b1) phase = -1;
                end

                if (stim_done && !final_chk) begin
                    final_chk = 1'b1;
                    check(nm("queue_empty"), 32'(sb.size()), 32'd0);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin : stimulus
        reset    = 1'b1;
        tx_start = 1'b0;
        tx_data  = 8'h00;
        repeat (3) step();
        reset  = 1'b0;
        mon_en = 1'b1;

        // Idle after reset.
        repeat (20) step();

        // Single 0xA5 frame, with ignored requests and data churn mid-frame.
        tx_data  = 8'hA5;
        tx_start = 1'b1;
        step();
        tx_start = 1'b0;
        repeat (10) step();
        tx_start = 1'b1;
        tx_data  = 8'h3C;
        step();
        tx_start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tx_data = 8'($urandom);
            step();
        end
        repeat (20) step();

        // tx_start held: back-to-back 0x00 then 0xFF.
        tx_start = 1'b1;
        tx_data  = 8'h00;
        repeat (20) step();
        tx_data = 8'hFF;
        repeat (30) step();
        tx_start = 1'b0;
        repeat (60) step();

        // Reset mid-DATA, then a clean 0x5A frame.
        tx_data  = 8'h96;
        tx_start = 1'b1;
        step();
        tx_start = 1'b0;
        repeat (14) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (3) step();
        tx_data  = 8'h5A;
        tx_start = 1'b1;
        step();
        tx_start = 1'b0;
        repeat (50) step();

        // Reset wins over a simultaneous tx_start.
        reset    = 1'b1;
        tx_start = 1'b1;
        tx_data  = 8'hC3;
        step();
        reset    = 1'b0;
        tx_start = 1'b0;
        repeat (5) step();

        // 0x81 frame.
        tx_data  = 8'h81;
        tx_start = 1'b1;
        step();
        tx_start = 1'b0;
        repeat (50) step();

        // Random requests, data and occasional resets.
        for (int i = 0; i < 4000; i++) begin
            tx_start = ($urandom_range(0, 7) == 0);
            tx_data  = 8'($urandom);
            reset    = ($urandom_range(0, 599) == 0);
            step();
        end
        reset    = 1'b0;
        tx_start = 1'b0;
        repeat (60) step();

        stim_done = 1'b1;
        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
